// File: rtl/display_select_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : display_select_scheduler_if
// Description : Board inputs, debug buses and mux-side outputs of the
//               display selector, bundled for the scheduler and its driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface display_select_scheduler_if;
    logic        key_next_n;
    logic        key_prev_n;
    logic        sw_auto;
    logic        sw_hold;
    logic [31:0] instr_bus;
    logic [31:0] rd1_bus;
    logic [31:0] rd2_bus;
    logic [31:0] result_bus;
    logic [1:0]  selm;
    logic [3:0]  sel_led;
    logic [31:0] snap_instr;
    logic [31:0] snap_rd1;
    logic [31:0] snap_rd2;
    logic [31:0] snap_result;
    logic        step_pulse;

    modport master (
        output key_next_n, key_prev_n, sw_auto, sw_hold,
        output instr_bus, rd1_bus, rd2_bus, result_bus,
        input  selm, sel_led, step_pulse,
        input  snap_instr, snap_rd1, snap_rd2, snap_result
    );

    modport slave (
        input  key_next_n, key_prev_n, sw_auto, sw_hold,
        input  instr_bus, rd1_bus, rd2_bus, result_bus,
        output selm, sel_led, step_pulse,
        output snap_instr, snap_rd1, snap_rd2, snap_result
    );
endinterface
`default_nettype wire

// File: rtl/display_select_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : display_select_scheduler
// Description : Debounced manual / timed auto stepping of the 2-bit hex-mux
//               selector, with hold-able snapshots of the four debug buses.
// Revision    : 1.0 - initial release
// ============================================================================
module display_select_scheduler #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DWELL_CYCLES    = 100000000,
    parameter int DB_W            = 20,
    parameter int DW_W            = 27
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    display_select_scheduler_if.slave    bus
);

    localparam logic [DB_W-1:0] c_DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW_W-1:0] c_DW_MAX   = DW_W'(DWELL_CYCLES - 1);
    localparam logic [0:0]      S_MANUAL   = 1'b0;
    localparam logic [0:0]      S_AUTO     = 1'b1;

    logic [1:0]      w_key_raw;
    logic [1:0]      w_key_evt;
    logic [1:0]      r_sw_meta;
    logic [1:0]      r_sw_sync;
    logic            w_sw_auto;
    logic            w_sw_hold;
    logic [0:0]      r_state;
    logic [DW_W-1:0] r_dwell;
    logic [1:0]      r_selm;
    logic [3:0]      r_sel_led;
    logic            r_step_pulse;
    logic [31:0]     r_snap_instr;
    logic [31:0]     r_snap_rd1;
    logic [31:0]     r_snap_rd2;
    logic [31:0]     r_snap_result;
    logic            w_next;
    logic            w_prev;
    logic            w_key_step;
    logic            w_auto_step;
    logic [1:0]      w_sel_nxt;

    assign w_key_raw = {bus.key_prev_n, bus.key_next_n};

    // Index 0 = next key, index 1 = prev key; both idle high.
    for (genvar k = 0; k < 2; k++) begin : g_key
        logic            r_meta;
        logic            r_sync;
        logic            r_db;
        logic            r_db_d;
        logic [DB_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_meta <= 1'b1;
                r_sync <= 1'b1;
                r_db   <= 1'b1;
                r_db_d <= 1'b1;
                r_cnt  <= '0;
            end else begin
                r_meta <= w_key_raw[k];
                r_sync <= r_meta;
                r_db_d <= r_db;
                if (r_sync != r_db) begin
                    if (r_cnt == c_DB_MAX) begin
                        r_db  <= r_sync;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        // Press only: debounced level falling from released to pressed.
        assign w_key_evt[k] = r_db_d & ~r_db;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_meta <= 2'b00;
            r_sw_sync <= 2'b00;
        end else begin
            r_sw_meta <= {bus.sw_hold, bus.sw_auto};
            r_sw_sync <= r_sw_meta;
        end
    end

    assign w_sw_auto = r_sw_sync[0];
    assign w_sw_hold = r_sw_sync[1];

    // Coincident next+prev cancel; a key step pre-empts a dwell expiry.
    assign w_next      = w_key_evt[0] & ~w_key_evt[1];
    assign w_prev      = w_key_evt[1] & ~w_key_evt[0];
    assign w_key_step  = w_next | w_prev;
    assign w_auto_step = (r_state == S_AUTO) && w_sw_auto && (r_dwell == c_DW_MAX);

    always_comb begin
        w_sel_nxt = r_selm;
        if (w_next) begin
            w_sel_nxt = r_selm + 2'd1;
        end else if (w_prev) begin
            w_sel_nxt = r_selm - 2'd1;
        end else if (w_auto_step) begin
            w_sel_nxt = r_selm + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_MANUAL;
            r_dwell      <= '0;
            r_selm       <= 2'b00;
            r_sel_led    <= 4'b0001;
            r_step_pulse <= 1'b0;
        end else begin
            case (r_state)
                S_MANUAL: begin
                    r_dwell <= '0;
                    if (w_sw_auto) begin
                        r_state <= S_AUTO;
                    end
                end
                S_AUTO: begin
                    if (!w_sw_auto) begin
                        r_state <= S_MANUAL;
                        r_dwell <= '0;
                    end else if (w_key_step || w_auto_step) begin
                        r_dwell <= '0;
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_MANUAL;
                    r_dwell <= '0;
                end
            endcase
            r_selm       <= w_sel_nxt;
            r_sel_led    <= 4'b0001 << w_sel_nxt;
            r_step_pulse <= w_key_step | w_auto_step;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap_instr  <= '0;
            r_snap_rd1    <= '0;
            r_snap_rd2    <= '0;
            r_snap_result <= '0;
        end else if (!w_sw_hold) begin
            r_snap_instr  <= bus.instr_bus;
            r_snap_rd1    <= bus.rd1_bus;
            r_snap_rd2    <= bus.rd2_bus;
            r_snap_result <= bus.result_bus;
        end
    end

    assign bus.selm        = r_selm;
    assign bus.sel_led     = r_sel_led;
    assign bus.step_pulse  = r_step_pulse;
    assign bus.snap_instr  = r_snap_instr;
    assign bus.snap_rd1    = r_snap_rd1;
    assign bus.snap_rd2    = r_snap_rd2;
    assign bus.snap_result = r_snap_result;

endmodule
`default_nettype wire
